// File: rtl/calibration_sequencer_pkg.sv
// Shared types for the calibration run sequencer: state encoding, latched
// run parameters and default pulse lengths.
package calibration_sequencer_pkg;

    localparam int START_LEN_DEF = 4;
    localparam int ABORT_LEN_DEF = 4;
    localparam int SEQ_CNT_W     = 32;

    typedef enum logic [7:0] {
        ST_IDLE      = 8'd0,
        ST_ARM       = 8'd1,
        ST_WAIT_TRIG = 8'd2,
        ST_WAIT_END  = 8'd3,
        ST_GAP       = 8'd4,
        ST_ABORT     = 8'd5,
        ST_FINISH    = 8'd6
    } seq_state_t;

    typedef struct packed {
        logic [15:0]          shot_count;
        logic [SEQ_CNT_W-1:0] shot_gap;
        logic [SEQ_CNT_W-1:0] shot_timeout;
    } seq_parameters_t;

endpackage

// File: rtl/calibration_sequencer_rise_detect.sv
// Rising-edge detector on a level input using a registered 2-bit history;
// the pulse appears one cycle after the input is first sampled high.
module rise_detect (
    input  logic clock,
    input  logic reset_signal,
    input  logic i_sig,
    output logic o_rise
);

    logic [1:0] r_hist;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_hist <= 2'b00;
        end else begin
            r_hist <= {r_hist[0], i_sig};
        end
    end

    assign o_rise = (r_hist == 2'b01);

endmodule

// File: rtl/calibration_sequencer.sv
// Run-level controller: issues shot_count start pulses to the calibration FSM,
// waits for each trigger to complete, spaces shots and aborts on timeout/request.
module calibration_sequencer
    import calibration_sequencer_pkg::*;
#(
    parameter int START_LEN = START_LEN_DEF,
    parameter int ABORT_LEN = ABORT_LEN_DEF,
    parameter int CNT_W     = SEQ_CNT_W
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             run_request,
    input  logic             abort_request,
    input  logic [15:0]      shot_count,
    input  logic [CNT_W-1:0] shot_gap,
    input  logic [CNT_W-1:0] shot_timeout,
    input  logic [7:0]       fsm_state,
    input  logic             fsm_trigger,
    output logic             fsm_start,
    output logic             fsm_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      shots_done,
    output logic [7:0]       seq_state
);

    seq_state_t           r_state;
    seq_parameters_t      r_params;
    logic [SEQ_CNT_W-1:0] r_cnt;
    logic [15:0]          r_shots_done;
    logic                 r_fsm_start;
    logic                 r_fsm_reset;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_run_rise;
    logic [SEQ_CNT_W-1:0] w_cnt_inc;
    logic [15:0]          w_shots_inc;
    logic                 w_abort_hit;
    logic                 w_timeout_hit;

    rise_detect u_run_rise (
        .clock        (clock),
        .reset_signal (reset_signal),
        .i_sig        (run_request),
        .o_rise       (w_run_rise)
    );

    // One shared counter serves start width, timeout, gap and abort width; it saturates.
    assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_shots_inc   = r_shots_done + 16'd1;
    assign w_abort_hit   = abort_request &&
                           (r_state inside {ST_ARM, ST_WAIT_TRIG, ST_WAIT_END, ST_GAP});
    assign w_timeout_hit = (r_state == ST_WAIT_TRIG) && !fsm_trigger &&
                           (r_params.shot_timeout != '0) &&
                           (w_cnt_inc >= r_params.shot_timeout);

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_state      <= ST_IDLE;
            r_params     <= '0;
            r_cnt        <= '0;
            r_shots_done <= '0;
            r_fsm_start  <= 1'b0;
            r_fsm_reset  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else if (w_abort_hit || w_timeout_hit) begin
            r_state     <= ST_ABORT;
            r_cnt       <= '0;
            r_fsm_start <= 1'b0;
            r_fsm_reset <= 1'b1;
            r_error     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_run_rise && !abort_request) begin
                        r_params.shot_count   <= shot_count;
                        r_params.shot_gap     <= SEQ_CNT_W'(shot_gap);
                        r_params.shot_timeout <= SEQ_CNT_W'(shot_timeout);
                        r_cnt                 <= '0;
                        r_shots_done          <= '0;
                        r_error               <= 1'b0;
                        if (shot_count == 16'd0) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= ST_ARM;
                            r_done      <= 1'b0;
                            r_busy      <= 1'b1;
                            r_fsm_start <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (r_cnt == SEQ_CNT_W'(START_LEN - 1)) begin
                        r_state     <= ST_WAIT_TRIG;
                        r_cnt       <= '0;
                        r_fsm_start <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (fsm_trigger) begin
                        r_state <= ST_WAIT_END;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_WAIT_END: begin
                    if (!fsm_trigger && (fsm_state == 8'd0)) begin
                        r_shots_done <= w_shots_inc;
                        r_cnt        <= '0;
                        if (w_shots_inc == r_params.shot_count) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (r_params.shot_gap == '0) begin
                            r_state     <= ST_ARM;
                            r_fsm_start <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_cnt_inc >= r_params.shot_gap) begin
                        r_state     <= ST_ARM;
                        r_cnt       <= '0;
                        r_fsm_start <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_ABORT: begin
                    if (r_cnt == SEQ_CNT_W'(ABORT_LEN - 1)) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_fsm_reset <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_start  = r_fsm_start;
    assign fsm_reset  = r_fsm_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign shots_done = r_shots_done;
    assign seq_state  = r_state;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Scoreboard bench for calibration_sequencer: a behavioural calibration-FSM model
// answers start pulses; expected run outcomes are queued and checked at run end.
module tb_calibration_sequencer;

    localparam int START_LEN = 4;
    localparam int ABORT_LEN = 4;
    localparam int CNT_W     = 32;
    localparam int TAIL      = 2;   // model keeps fsm_state busy this long after trigger falls

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_TIMEOUT = 1;
    localparam int MODE_ABORT   = 2;
    localparam int MODE_RESET   = 3;

    logic             clock = 1'b0;
    logic             reset_signal;
    logic             run_request;
    logic             abort_request;
    logic [15:0]      shot_count;
    logic [CNT_W-1:0] shot_gap;
    logic [CNT_W-1:0] shot_timeout;
    logic [7:0]       fsm_state;
    logic             fsm_trigger;
    logic             fsm_start;
    logic             fsm_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [15:0]      shots_done;
    logic [7:0]       seq_state;

    calibration_sequencer #(
        .START_LEN (START_LEN),
        .ABORT_LEN (ABORT_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clock         (clock),
        .reset_signal  (reset_signal),
        .run_request   (run_request),
        .abort_request (abort_request),
        .shot_count    (shot_count),
        .shot_gap      (shot_gap),
        .shot_timeout  (shot_timeout),
        .fsm_state     (fsm_state),
        .fsm_trigger   (fsm_trigger),
        .fsm_start     (fsm_start),
        .fsm_reset     (fsm_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .shots_done    (shots_done),
        .seq_state     (seq_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int shots;
        bit done;
        bit err;
        int starts;
        int resets;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Calibration FSM model controls
    bit   m_never = 1'b0;
    int   m_delay = 1;
    int   m_len   = 1;
    int   m_shots = 0;
    int   m_phase = 0;
    int   m_cnt   = 0;

    // Monitor bookkeeping shared with stimulus
    bit   mon_en      = 1'b0;
    int   cyc         = 0;
    int   runs_ended  = 0;
    int   exp_low     = -1;
    int   exp_to      = 0;
    int   abort_cyc   = -1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Outcome of one run derived from the run rules alone.
    function automatic exp_t predict(input int n, input int mode, input int k);
        exp_t e;
        e = '{shots: 0, done: 1'b0, err: 1'b0, starts: 0, resets: 0};
        case (mode)
            MODE_NORMAL:  begin e.shots = n; e.done = 1'b1; e.starts = n; end
            MODE_TIMEOUT: begin e.err = 1'b1; e.starts = 1; e.resets = ABORT_LEN; end
            MODE_ABORT:   begin e.shots = k; e.err = 1'b1; e.starts = k; e.resets = ABORT_LEN; end
            default:      begin e.starts = 1; end
        endcase
        return e;
    endfunction

    // Behavioural calibration FSM: trigger m_delay cycles after start falls,
    // high for m_len cycles, then busy TAIL more cycles before returning to IDLE.
    initial begin
        fsm_trigger = 1'b0;
        fsm_state   = 8'd0;
        forever begin
            @(posedge clock);
            #1;
            if (reset_signal || fsm_reset) begin
                m_phase = 0; fsm_trigger = 1'b0; fsm_state = 8'd0;
            end else begin
                case (m_phase)
                    0: if (fsm_start) begin m_phase = 1; fsm_state = 8'd3; end
                    1: if (!fsm_start) begin m_cnt = 0; m_phase = m_never ? 5 : 2; end
                    2: begin
                        m_cnt++;
                        if (m_cnt >= m_delay) begin fsm_trigger = 1'b1; m_cnt = 0; m_phase = 3; end
                    end
                    3: begin
                        m_cnt++;
                        if (m_cnt >= m_len) begin fsm_trigger = 1'b0; m_cnt = 0; m_phase = 4; end
                    end
                    4: begin
                        m_cnt++;
                        if (m_cnt >= TAIL) begin fsm_state = 8'd0; m_phase = 0; m_shots++; end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: pulse shapes and latencies on the fly, run outcome on return to IDLE.
    initial begin
        logic [7:0] prev_state = 8'd0;
        logic       prev_start = 1'b0;
        logic       prev_reset = 1'b0;
        int run_starts = 0, run_resets = 0, start_w = 0, low_len = 0, start_fall_cyc = 0;
        bit have_pulse = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (mon_en) begin
                if (fsm_start && !prev_start) begin
                    run_starts++;
                    if (have_pulse && exp_low >= 0) check("start_interval", low_len, exp_low);
                    start_w = 1;
                end else if (fsm_start) begin
                    start_w++;
                end else if (prev_start) begin
                    check("start_width", start_w, START_LEN);
                    have_pulse = 1'b1;
                    low_len = 1;
                    start_fall_cyc = cyc;
                end else begin
                    low_len++;
                end
                if (fsm_reset) begin
                    run_resets++;
                    if (!prev_reset) begin
                        if (exp_to > 0) check("timeout_latency", cyc - start_fall_cyc, exp_to);
                        if (abort_cyc >= 0) check("abort_latency", cyc - abort_cyc, 2);
                    end
                end
                if (prev_state != 8'd0 && seq_state == 8'd0) begin
                    runs_ended++;
                    check("run_end_queued", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("shots_done", shots_done, e.shots);
                        check("done", done, e.done);
                        check("error", error, e.err);
                        check("busy_at_end", busy, 0);
                        check("start_pulses", run_starts, e.starts);
                        check("reset_cycles", run_resets, e.resets);
                    end
                    run_starts = 0; run_resets = 0; have_pulse = 1'b0;
                end
            end
            prev_state = seq_state;
            prev_start = fsm_start;
            prev_reset = fsm_reset;
        end
    end

    task automatic issue_run(input int n, input int gap, input int to, input int mode,
                             input int k, input int d, input int len);
        m_never   = (mode == MODE_TIMEOUT) || (mode == MODE_RESET);
        m_delay   = d;
        m_len     = len;
        m_shots   = 0;
        exp_low   = d + len + TAIL + 1 + gap;
        exp_to    = (mode == MODE_TIMEOUT) ? to : 0;
        abort_cyc = -1;
        exp_q.push_back(predict(n, mode, k));
        shot_count   = 16'(n);
        shot_gap     = CNT_W'(gap);
        shot_timeout = CNT_W'(to);
        run_request  = 1'b1;
        tick(2);
        check("accept_busy", busy, (n != 0));
        check("accept_done", done, (n == 0));
        check("accept_error", error, 0);
        check("accept_shots", shots_done, 0);
        // Latched at acceptance: later input changes must not matter.
        shot_count   = 16'($urandom_range(0, 9));
        shot_gap     = CNT_W'($urandom_range(0, 3));
        shot_timeout = CNT_W'($urandom_range(1, 3));
        run_request  = 1'b0;
        if (mode == MODE_NORMAL && n != 0) begin
            tick(1);
            run_request = 1'b1;
            tick(2);
            run_request = 1'b0;
        end
    endtask

    task automatic wait_run_end(input int target, input int budget);
        for (int i = 0; i < budget && runs_ended < target; i++) tick(1);
        check("run_end_reached", runs_ended, target);
        if (runs_ended < target) finish_tb();
        tick(2);
    endtask

    initial begin
        int tgt, d, to;
        reset_signal  = 1'b1;
        run_request   = 1'b0;
        abort_request = 1'b0;
        shot_count    = '0;
        shot_gap      = '0;
        shot_timeout  = '0;
        tick(3);
        check("rst_fsm_start", fsm_start, 0);
        check("rst_fsm_reset", fsm_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_seq_state", seq_state, 0);
        reset_signal = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Normal run: 3 shots, gap 10, trigger 5 cycles after start, 100 long
        tgt = runs_ended + 1;
        issue_run(3, 10, 0, MODE_NORMAL, 0, 5, 100);
        wait_run_end(tgt, 2000);

        // Zero shots
        tgt = runs_ended + 1;
        issue_run(0, 3, 0, MODE_NORMAL, 0, 1, 1);
        wait_run_end(tgt, 20);

        // Timeout on first shot
        tgt = runs_ended + 1;
        issue_run(2, 4, 50, MODE_TIMEOUT, 0, 1, 1);
        wait_run_end(tgt, 500);

        // Abort during the gap after shot 2 (acceptance checks cover error clearing)
        tgt = runs_ended + 1;
        issue_run(5, 200, 0, MODE_ABORT, 2, 3, 6);
        for (int i = 0; i < 1000 && m_shots < 2; i++) tick(1);
        check("abort_setup_shots", m_shots, 2);
        tick(3);
        abort_request = 1'b1;
        abort_cyc = cyc;
        tick(1);
        check("abort_state", seq_state, 5);
        abort_request = 1'b0;
        wait_run_end(tgt, 100);

        // Run edge together with abort in IDLE is ignored
        abort_request = 1'b1;
        run_request   = 1'b1;
        shot_count    = 16'd2;
        tick(3);
        abort_request = 1'b0;
        tick(3);
        check("blocked_state", seq_state, 0);
        check("blocked_busy", busy, 0);
        check("blocked_start", fsm_start, 0);
        run_request = 1'b0;
        tick(2);

        // Reset in WAIT_TRIG
        tgt = runs_ended + 1;
        issue_run(2, 0, 0, MODE_RESET, 0, 1, 1);
        for (int i = 0; i < 50 && seq_state != 8'd2; i++) tick(1);
        check("reached_wait_trig", seq_state, 2);
        tick(3);
        reset_signal = 1'b1;
        tick(1);
        check("midrst_fsm_start", fsm_start, 0);
        check("midrst_fsm_reset", fsm_reset, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        check("midrst_shots", shots_done, 0);
        check("midrst_state", seq_state, 0);
        reset_signal = 1'b0;
        wait_run_end(tgt, 10);

        // Randomised normal runs
        for (int r = 0; r < 6; r++) begin
            d  = $urandom_range(1, 8);
            to = ($urandom_range(0, 1) == 0) ? 0 : d + 2 + $urandom_range(0, 20);
            tgt = runs_ended + 1;
            issue_run($urandom_range(0, 4), $urandom_range(0, 12), to, MODE_NORMAL, 0,
                      d, $urandom_range(1, 30));
            wait_run_end(tgt, 3000);
        end

        check("queue_drained", exp_q.size(), 0);
        finish_tb();
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        finish_tb();
    end

endmodule
